regfile_sb: RTL and testbench

- Parametrised register file for the RISC-V core.
- Configurable width, depth and read-port count.
- Adds write-to-read bypass, a per-register pending-write scoreboard with stall flags, a pipeline-flush clear and an arbitrary-index debug tap.
- Sits between decode (read and issue), writeback (write) and the board debug/LED logic.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_sb_if.sv | 38 +++
 rtl/regfile_sb_rf_read_port.sv | 37 +++
 rtl/regfile_sb.sv | 88 ++++++++
 tb/tb_regfile_sb.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the regfile_sb register file
// Purpose: default geometry, index-width helper and the hardwired-zero register index.
// Ports: none (package).
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NREAD = 2;

  // Index of the architectural zero register.
  localparam int ZERO_REG = 0;

  // Index width for a register file of n entries (n is a power of two, n >= 2).
  function automatic int calc_aw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - decode/writeback/debug bus of the regfile_sb register file
// Purpose: bundles read ports, issue, writeback, flush and debug tap signals.
// Ports (signals): rs_addr/rs_data/rs_busy (packed read ports), iss_valid/iss_rd (reserve),
//   wb_en/wb_rd/wb_data (writeback), flush, dbg_addr/dbg_data (debug tap), busy_any.
// Modports: master drives requests (decode/writeback/debug side), slave is the register file.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NREAD = DEF_NREAD
);
  localparam int AW = calc_aw(NREGS);

  logic [NREAD*AW-1:0]   rs_addr;
  logic [NREAD*XLEN-1:0] rs_data;
  logic [NREAD-1:0]      rs_busy;
  logic                  iss_valid;
  logic [AW-1:0]         iss_rd;
  logic                  wb_en;
  logic [AW-1:0]         wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  flush;
  logic [AW-1:0]         dbg_addr;
  logic [XLEN-1:0]       dbg_data;
  logic                  busy_any;

  modport master (
    output rs_addr, iss_valid, iss_rd, wb_en, wb_rd, wb_data, flush, dbg_addr,
    input  rs_data, rs_busy, dbg_data, busy_any
  );

  modport slave (
    input  rs_addr, iss_valid, iss_rd, wb_en, wb_rd, wb_data, flush, dbg_addr,
    output rs_data, rs_busy, dbg_data, busy_any
  );

endinterface

// File: rtl/regfile_sb_rf_read_port.sv
// rtl/regfile_sb_rf_read_port.sv - one combinational read port with zero, bypass and busy resolution
// Purpose: resolves a single source operand from storage, scoreboard and in-flight writeback.
// Ports: i_addr (source index), i_mem_data (stored value at i_addr), i_sb_bit (scoreboard bit
//   at i_addr), i_wb_en/i_wb_rd/i_wb_data (writeback this cycle), o_data/o_busy (resolved operand).
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   i_addr,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic            i_sb_bit,
  input  logic            i_wb_en,
  input  logic [AW-1:0]   i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic [XLEN-1:0] o_data,
  output logic            o_busy
);

  always_comb begin
    o_data = '0;
    o_busy = 1'b0;
    if (i_addr == AW'(ZERO_REG)) begin
      o_data = '0;
      o_busy = 1'b0;
    end else if (i_wb_en && (i_wb_rd == i_addr)) begin
      // The producer is writing back right now, so the operand is ready.
      o_data = i_wb_data;
      o_busy = 1'b0;
    end else begin
      o_data = i_mem_data;
      o_busy = i_sb_bit;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with write-to-read bypass, pending-write scoreboard and debug tap
// Purpose: storage and scoreboard for the RISC-V core between decode, writeback and debug logic.
// Ports: clk (posedge clock), AReset (async active-low reset), bus (regfile_sb_if.slave:
//   read ports, issue reservation, writeback, flush, debug tap, busy_any).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NREAD = DEF_NREAD
) (
  input logic        clk,
  input logic        AReset,
  regfile_sb_if.slave bus
);

  localparam int AW = calc_aw(NREGS);

  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] r_sb;
  logic [NREGS-1:0] w_sb_next;
  logic             w_wb_write;
  logic             w_wb_bypass;
  logic [XLEN-1:0]  w_rd_mem  [NREAD];
  logic [XLEN-1:0]  w_rd_data [NREAD];
  logic             w_rd_busy [NREAD];

  assign w_wb_write  = bus.wb_en && (bus.wb_rd != AW'(ZERO_REG));
  // Bypass is gated by reset so every read port shows 0 while reset is held.
  assign w_wb_bypass = bus.wb_en && AReset;

  // Storage; entry 0 is never written and stays zero after reset.
  always_ff @(posedge clk or negedge AReset) begin
    if (!AReset) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (w_wb_write) begin
      r_mem[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Flush beats everything; otherwise writeback clears, then issue sets,
  // so a same-cycle issue and writeback to one rd leaves the bit set.
  always_comb begin
    w_sb_next = r_sb;
    if (bus.flush) begin
      w_sb_next = '0;
    end else begin
      if (w_wb_write) w_sb_next[bus.wb_rd] = 1'b0;
      if (bus.iss_valid && (bus.iss_rd != AW'(ZERO_REG))) w_sb_next[bus.iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge AReset) begin
    if (!AReset) r_sb <= '0;
    else         r_sb <= w_sb_next;
  end

  for (genvar k = 0; k < NREAD; k++) begin : gen_port
    logic [AW-1:0] w_addr;
    assign w_addr      = bus.rs_addr[k*AW +: AW];
    assign w_rd_mem[k] = r_mem[w_addr];

    rf_read_port #(.XLEN(XLEN), .AW(AW)) u_port (
      .i_addr     (w_addr),
      .i_mem_data (w_rd_mem[k]),
      .i_sb_bit   (r_sb[w_addr]),
      .i_wb_en    (w_wb_bypass),
      .i_wb_rd    (bus.wb_rd),
      .i_wb_data  (bus.wb_data),
      .o_data     (w_rd_data[k]),
      .o_busy     (w_rd_busy[k])
    );
  end

  always_comb begin
    bus.rs_data = '0;
    bus.rs_busy = '0;
    for (int k = 0; k < NREAD; k++) begin
      bus.rs_data[k*XLEN +: XLEN] = w_rd_data[k];
      bus.rs_busy[k]              = w_rd_busy[k];
    end
  end

  // Debug tap sees raw storage only, never the bypass path.
  assign bus.dbg_data = (bus.dbg_addr == AW'(ZERO_REG)) ? '0 : r_mem[bus.dbg_addr];
  assign bus.busy_any = |r_sb;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb (default and 3-port/16-reg/64-bit builds)
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst0;
  logic rst6;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus0 ();
  regfile_sb_if #(.XLEN(64), .NREGS(16), .NREAD(3)) bus6 ();

  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2)) u_dut (
    .clk    (clk),
    .AReset (rst0),
    .bus    (bus0.slave)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .NREAD(3)) u_dut6 (
    .clk    (clk),
    .AReset (rst6),
    .bus    (bus6.slave)
  );

  // Reference model of the default build.
  logic [31:0] m_mem [32];
  bit          m_sb  [32];

  task automatic idle0();
    bus0.rs_addr = '0; bus0.iss_valid = 1'b0; bus0.iss_rd = '0;
    bus0.wb_en = 1'b0; bus0.wb_rd = '0; bus0.wb_data = '0;
    bus0.flush = 1'b0; bus0.dbg_addr = '0;
  endtask

  task automatic idle6();
    bus6.rs_addr = '0; bus6.iss_valid = 1'b0; bus6.iss_rd = '0;
    bus6.wb_en = 1'b0; bus6.wb_rd = '0; bus6.wb_data = '0;
    bus6.flush = 1'b0; bus6.dbg_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b0;
    idle0();
    bus0.rs_addr = {5'd5, 5'd5};
    bus0.dbg_addr = 5'd5;
    bus0.wb_en = 1'b1; bus0.wb_rd = 5'd5; bus0.wb_data = 32'hDEADBEEF;
    bus0.iss_valid = 1'b1; bus0.iss_rd = 5'd5;
    #1;
    n_vec++; if (bus0.rs_data !== 64'h0) begin n_err++; $display("FAIL reset_bypass_held got=%h exp=0", bus0.rs_data); end
    tick();
    n_vec++; if (bus0.rs_data !== 64'h0) begin n_err++; $display("FAIL reset_data_held got=%h exp=0", bus0.rs_data); end
    n_vec++; if (bus0.dbg_data !== 32'h0) begin n_err++; $display("FAIL reset_dbg got=%h exp=0", bus0.dbg_data); end
    n_vec++; if (bus0.rs_busy !== 2'b00 || bus0.busy_any !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b/%b exp=00/0", bus0.rs_busy, bus0.busy_any); end
    idle0();
    rst0 = 1'b1;
    bus0.wb_en = 1'b1; bus0.wb_rd = 5'd0; bus0.wb_data = 32'h1234;
    bus0.rs_addr = {5'd5, 5'd0};
    #1;
    n_vec++; if (bus0.rs_data[31:0] !== 32'h0) begin n_err++; $display("FAIL x0_bypass got=%h exp=0", bus0.rs_data[31:0]); end
    tick();
    idle0();
    bus0.rs_addr = {5'd5, 5'd0};
    #1;
    n_vec++; if (bus0.rs_data[31:0] !== 32'h0) begin n_err++; $display("FAIL x0_stored got=%h exp=0", bus0.rs_data[31:0]); end
    n_vec++; if (bus0.rs_data[63:32] !== 32'h0) begin n_err++; $display("FAIL x5_after_reset got=%h exp=0", bus0.rs_data[63:32]); end
    tick();
  endtask

  task automatic test_write_read();
    idle0();
    bus0.wb_en = 1'b1; bus0.wb_rd = 5'd7; bus0.wb_data = 32'hA5A5A5A5;
    bus0.rs_addr = {5'd0, 5'd7};
    bus0.dbg_addr = 5'd7;
    #1;
    n_vec++; if (bus0.rs_data[31:0] !== 32'hA5A5A5A5 || bus0.rs_busy[0] !== 1'b0) begin n_err++; $display("FAIL wr_bypass got=%h/%b exp=a5a5a5a5/0", bus0.rs_data[31:0], bus0.rs_busy[0]); end
    n_vec++; if (bus0.dbg_data !== 32'h0) begin n_err++; $display("FAIL wr_dbg_same_cycle got=%h exp=0", bus0.dbg_data); end
    tick();
    bus0.wb_en = 1'b0;
    #1;
    n_vec++; if (bus0.rs_data[31:0] !== 32'hA5A5A5A5) begin n_err++; $display("FAIL wr_stored got=%h exp=a5a5a5a5", bus0.rs_data[31:0]); end
    n_vec++; if (bus0.dbg_data !== 32'hA5A5A5A5) begin n_err++; $display("FAIL wr_dbg_next got=%h exp=a5a5a5a5", bus0.dbg_data); end
    tick();
  endtask

  task automatic test_scoreboard();
    idle0();
    bus0.iss_valid = 1'b1; bus0.iss_rd = 5'd3;
    bus0.rs_addr = {5'd0, 5'd3};
    #1;
    n_vec++; if (bus0.rs_busy[0] !== 1'b0) begin n_err++; $display("FAIL sb_issue_cycle got=%b exp=0", bus0.rs_busy[0]); end
    tick();
    bus0.iss_valid = 1'b0;
    #1;
    n_vec++; if (bus0.rs_busy[0] !== 1'b1 || bus0.busy_any !== 1'b1) begin n_err++; $display("FAIL sb_set got=%b/%b exp=1/1", bus0.rs_busy[0], bus0.busy_any); end
    tick(); tick(); tick();
    bus0.wb_en = 1'b1; bus0.wb_rd = 5'd3; bus0.wb_data = 32'h55;
    #1;
    n_vec++; if (bus0.rs_busy[0] !== 1'b0 || bus0.rs_data[31:0] !== 32'h55) begin n_err++; $display("FAIL sb_wb_bypass got=%b/%h exp=0/55", bus0.rs_busy[0], bus0.rs_data[31:0]); end
    n_vec++; if (bus0.busy_any !== 1'b1) begin n_err++; $display("FAIL sb_any_wb_cycle got=%b exp=1", bus0.busy_any); end
    tick();
    bus0.wb_en = 1'b0;
    #1;
    n_vec++; if (bus0.busy_any !== 1'b0 || bus0.rs_data[31:0] !== 32'h55) begin n_err++; $display("FAIL sb_cleared got=%b/%h exp=0/55", bus0.busy_any, bus0.rs_data[31:0]); end
    tick();
  endtask

  task automatic test_same_cycle();
    idle0();
    bus0.iss_valid = 1'b1; bus0.iss_rd = 5'd9;
    bus0.wb_en = 1'b1; bus0.wb_rd = 5'd9; bus0.wb_data = 32'h99;
    tick();
    idle0();
    bus0.rs_addr = {5'd9, 5'd0};
    #1;
    n_vec++; if (bus0.rs_busy[1] !== 1'b1 || bus0.busy_any !== 1'b1) begin n_err++; $display("FAIL same_sb got=%b/%b exp=1/1", bus0.rs_busy[1], bus0.busy_any); end
    n_vec++; if (bus0.rs_data[63:32] !== 32'h99) begin n_err++; $display("FAIL same_data got=%h exp=99", bus0.rs_data[63:32]); end
    tick();
  endtask

  task automatic test_flush();
    idle0();
    bus0.iss_valid = 1'b1;
    bus0.iss_rd = 5'd1; tick();
    bus0.iss_rd = 5'd2; tick();
    bus0.iss_rd = 5'd4; tick();
    bus0.iss_valid = 1'b0;
    bus0.rs_addr = {5'd2, 5'd4};
    #1;
    n_vec++; if (bus0.rs_busy !== 2'b11) begin n_err++; $display("FAIL flush_reserved got=%b exp=11", bus0.rs_busy); end
    bus0.flush = 1'b1;
    bus0.iss_valid = 1'b1; bus0.iss_rd = 5'd6;
    bus0.wb_en = 1'b1; bus0.wb_rd = 5'd2; bus0.wb_data = 32'h77;
    tick();
    idle0();
    bus0.rs_addr = {5'd2, 5'd6};
    #1;
    n_vec++; if (bus0.busy_any !== 1'b0) begin n_err++; $display("FAIL flush_any got=%b exp=0", bus0.busy_any); end
    n_vec++; if (bus0.rs_busy[0] !== 1'b0) begin n_err++; $display("FAIL flush_x6 got=%b exp=0", bus0.rs_busy[0]); end
    n_vec++; if (bus0.rs_data[63:32] !== 32'h77 || bus0.rs_busy[1] !== 1'b0) begin n_err++; $display("FAIL flush_x2 got=%h/%b exp=77/0", bus0.rs_data[63:32], bus0.rs_busy[1]); end
    tick();
  endtask

  task automatic test_random(input int n);
    logic [4:0]  a [2];
    logic [31:0] exp_d;
    bit          exp_b;
    bit          exp_any;
    idle0();
    rst0 = 1'b0;
    #1;
    rst0 = 1'b1;
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_sb[i] = 1'b0; end
    tick();
    for (int c = 0; c < n; c++) begin
      a[0] = 5'($urandom_range(0, 31));
      a[1] = ($urandom_range(0, 3) == 0) ? a[0] : 5'($urandom_range(0, 31));
      bus0.rs_addr   = {a[1], a[0]};
      bus0.wb_en     = 1'($urandom_range(0, 1));
      bus0.wb_rd     = ($urandom_range(0, 2) == 0) ? a[c % 2] : 5'($urandom_range(0, 31));
      bus0.wb_data   = $urandom;
      bus0.iss_valid = 1'($urandom_range(0, 1));
      bus0.iss_rd    = ($urandom_range(0, 3) == 0) ? bus0.wb_rd : 5'($urandom_range(0, 31));
      bus0.flush     = ($urandom_range(0, 15) == 0);
      bus0.dbg_addr  = 5'($urandom_range(0, 31));
      #1;
      for (int k = 0; k < 2; k++) begin
        if (a[k] == 0) begin
          exp_d = 0; exp_b = 0;
        end else if (bus0.wb_en && bus0.wb_rd == a[k]) begin
          exp_d = bus0.wb_data; exp_b = 0;
        end else begin
          exp_d = m_mem[a[k]]; exp_b = m_sb[a[k]];
        end
        n_vec++;
        if (bus0.rs_data[k*32 +: 32] !== exp_d || bus0.rs_busy[k] !== exp_b) begin
          n_err++;
          $display("FAIL rand_port%0d cyc=%0d addr=%0d got=%h/%b exp=%h/%b", k, c, a[k], bus0.rs_data[k*32 +: 32], bus0.rs_busy[k], exp_d, exp_b);
        end
      end
      exp_any = 0;
      for (int i = 0; i < 32; i++) exp_any |= m_sb[i];
      n_vec++;
      if (bus0.busy_any !== exp_any) begin n_err++; $display("FAIL rand_busy_any cyc=%0d got=%b exp=%b", c, bus0.busy_any, exp_any); end
      n_vec++;
      if (bus0.dbg_data !== m_mem[bus0.dbg_addr]) begin n_err++; $display("FAIL rand_dbg cyc=%0d addr=%0d got=%h exp=%h", c, bus0.dbg_addr, bus0.dbg_data, m_mem[bus0.dbg_addr]); end
      tick();
      if (bus0.wb_en && bus0.wb_rd != 0) m_mem[bus0.wb_rd] = bus0.wb_data;
      if (bus0.flush) begin
        for (int i = 0; i < 32; i++) m_sb[i] = 1'b0;
      end else begin
        if (bus0.wb_en && bus0.wb_rd != 0) m_sb[bus0.wb_rd] = 1'b0;
        if (bus0.iss_valid && bus0.iss_rd != 0) m_sb[bus0.iss_rd] = 1'b1;
      end
    end
    idle0();
  endtask

  task automatic test_param_sweep();
    idle6();
    bus6.wb_en = 1'b1; bus6.wb_rd = 4'd15; bus6.wb_data = 64'h0123456789ABCDEF;
    bus6.rs_addr = {4'd0, 4'd15, 4'd15};
    #1;
    n_vec++; if (bus6.rs_data[63:0] !== 64'h0123456789ABCDEF || bus6.rs_data[127:64] !== 64'h0123456789ABCDEF) begin n_err++; $display("FAIL p6_bypass got=%h/%h exp=0123456789abcdef", bus6.rs_data[63:0], bus6.rs_data[127:64]); end
    n_vec++; if (bus6.rs_data[191:128] !== 64'h0 || bus6.rs_busy !== 3'b000) begin n_err++; $display("FAIL p6_x0_busy got=%h/%b exp=0/000", bus6.rs_data[191:128], bus6.rs_busy); end
    tick();
    idle6();
    bus6.iss_valid = 1'b1; bus6.iss_rd = 4'd5;
    bus6.rs_addr = {4'd0, 4'd0, 4'd15};
    tick();
    idle6();
    bus6.rs_addr = {4'd0, 4'd5, 4'd15};
    #1;
    n_vec++; if (bus6.rs_data[63:0] !== 64'h0123456789ABCDEF || bus6.rs_busy !== 3'b010 || bus6.busy_any !== 1'b1) begin n_err++; $display("FAIL p6_stored got=%h/%b/%b exp=0123456789abcdef/010/1", bus6.rs_data[63:0], bus6.rs_busy, bus6.busy_any); end
    #1;
    rst6 = 1'b0;
    #1;
    n_vec++; if (bus6.rs_data !== 192'h0 || bus6.rs_busy !== 3'b000 || bus6.busy_any !== 1'b0) begin n_err++; $display("FAIL p6_async_held got=%h/%b/%b exp=0/000/0", bus6.rs_data, bus6.rs_busy, bus6.busy_any); end
    rst6 = 1'b1;
    #1;
    n_vec++; if (bus6.rs_data[63:0] !== 64'h0 || bus6.busy_any !== 1'b0) begin n_err++; $display("FAIL p6_async_after got=%h/%b exp=0/0", bus6.rs_data[63:0], bus6.busy_any); end
    tick();
  endtask

  initial begin
    rst0 = 1'b0;
    rst6 = 1'b0;
    idle0();
    idle6();
    tick();
    tick();
    rst6 = 1'b1;
    test_reset();
    test_write_read();
    test_scoreboard();
    test_same_cycle();
    test_flush();
    test_random(400);
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
